tt_um_seq_divider_hhrb98: RTL and testbench
===========================================

// Module: tt_um_seq_divider_hhrb98
// PURPOSE
//  Sequential restoring divider: 8-bit dividend / 4-bit divisor -> 8-bit quotient + 4-bit remainder.
//  Inverse companion of the 4x4 array multiplier tile; dividend/divisor arrive on TT pins, results go out on uo_out.
//  Resolves one quotient bit per clock, using a start/busy/done handshake; results hold until the next start.
// PARAMETERS (localparams, fixed by TT pinout)
//  N_BITS   8  dividend and quotient width
//  D_BITS   4  divisor and remainder width
// PORTS
//  clk      in   1  single clock
//  rst_n    in   1  asynchronous active-low reset
//  ena      in   1  TT enable; 0 freezes all state (no capture, no iteration)
//  ui_in    in   8  dividend, sampled at start acceptance
//  uio_in   in   8  [3:0] divisor, [4] start, [5] out_sel; [7:6] ignored
//  uo_out   out  8  out_sel=0: quotient; out_sel=1: {dbz, 3'b000, remainder}
//  uio_out  out  8  [7] done, [6] busy, [5:0] = 0
//  uio_oe   out  8  constant 8'b1100_0000
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, quot=0, rem=0, dbz=0, done=0, busy=0, cnt=0, A=0.
//    Outputs go to these values immediately, independent of clk; this includes an abort mid-RUN.
//  Datapath: A = 5-bit partial remainder; Q = 8-bit shift register; D = 4-bit divisor; cnt = 3-bit counter.
//  FSM states: IDLE, RUN, DONE. All transitions are qualified by ena=1.
//  Start acceptance: at a clk edge with start=1 and state in {IDLE, DONE}:
//    - capture Q<=ui_in, D<=uio_in[3:0], A<=0, cnt<=0.
//    - D!=0: state<=RUN, busy<=1, done<=0, dbz<=0.
//    - D==0: state<=DONE directly (1-cycle latency), quot<=8'hFF, rem<=4'hF, dbz<=1, done<=1.
//  Start is level-sampled. Held high in DONE, it restarts at every acceptance edge.
//  Start is ignored while in RUN.
//  RUN edge: S={A[3:0],Q[7]}; T=S-{1'b0,D}.
//    - T>=0: A<=T, Q<={Q[6:0],1}.
//    - T<0:  A<=S, Q<={Q[6:0],0}.
//    - cnt<=cnt+1.
//  On the RUN edge with cnt==7: state<=DONE, busy<=0, done<=1, quot<=final Q, rem<=final A[3:0].
//  Latency: done rises on the 8th edge after the acceptance edge; throughput is 1 divide per 9 cycles.
//  DONE: quot/rem/dbz/done hold until the next accepted start or reset.
//    done clears on the acceptance edge; busy rises on that same edge.
//  IDLE: reached only from reset. Outputs read as zero there.
//  out_sel is a purely combinational mux onto uo_out; it may change in any state without affecting the datapath.
//  ena=0 during RUN: the iteration pauses; it resumes exactly where it stopped when ena returns to 1.
//  Invariants:
//    - busy and done are never both 1.
//    - A[4] is never 1 after an update.
//    - rem < D whenever dbz=0.
// TESTING
//  200/7: start 1 cycle -> busy for 8 cycles; then done=1, quot=28 (8'h1C); sel=1 -> uo_out=8'h04.
//  255/1 and 0/15: quot=255/rem=0 and quot=0/rem=0. Also 9/13 -> quot=0, rem=9 (divisor > dividend).
//  15/0: done 1 cycle after start, busy never rises; quot=8'hFF; sel=1 -> uo_out=8'h8F.
//  Reset mid-RUN: drop rst_n at cycle 4 -> outputs 0 without a clk edge; a new 100/3 then gives 33 r1.
//  Back-to-back: start held high, alternating 100/3 and 77/5 -> each result 33 r1 and 15 r2.
//    Check that done clears on each acceptance edge and that start pulses during RUN are ignored.
//  ena=0 for 3 cycles mid-RUN -> result unchanged, done delayed by exactly 3 cycles.
//    Random sweep of all 4096 operand pairs vs reference model: quot*D+rem==dividend, rem<D.

Source files
------------

// File: rtl/tt_um_seq_divider_hhrb98.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; results and the divide-by-zero flag hold until the next accepted start.
module tt_um_seq_divider_hhrb98 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int N_BITS = 8;
    localparam int D_BITS = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [D_BITS:0]     a;
    logic [N_BITS-1:0]   q;
    logic [D_BITS-1:0]   d;
    logic [2:0]          cnt;
    logic [N_BITS-1:0]   quot;
    logic [D_BITS-1:0]   rem;
    logic                dbz;
    logic                done;
    logic                busy;

    logic [D_BITS-1:0]   divisor;
    logic                start;
    logic                out_sel;
    logic [D_BITS:0]     s;
    logic [D_BITS+1:0]   t;
    logic                fits;
    logic [D_BITS:0]     a_next;
    logic [N_BITS-1:0]   q_next;

    assign divisor = uio_in[D_BITS-1:0];
    assign start   = uio_in[4];
    assign out_sel = uio_in[5];

    // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
    // The partial remainder is always < D, so a[4] stays clear and only a[3:0] feeds the shift.
    always_comb begin
        s      = {a[D_BITS-1:0], q[N_BITS-1]};
        t      = {1'b0, s} - {2'b00, d};
        fits   = ~t[D_BITS+1];
        a_next = fits ? t[D_BITS:0] : s;
        q_next = {q[N_BITS-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q   <= ui_in;
                        d   <= divisor;
                        a   <= '0;
                        cnt <= '0;
                        if (divisor != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            dbz   <= 1'b0;
                        end else begin
                            // Divide by zero finishes immediately with all-ones results.
                            state <= DONE;
                            quot  <= '1;
                            rem   <= '1;
                            dbz   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    a   <= a_next;
                    q   <= q_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        quot  <= q_next;
                        rem   <= a_next[D_BITS-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = out_sel ? {dbz, 3'b000, rem} : quot;
    assign uio_out = {done, busy, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:6], a[D_BITS]};
endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Directed bench for the sequential divider: handshake timing, boundary operands,
// async reset abort, back-to-back starts, ena pause and a full operand sweep.
module tb_tt_um_seq_divider_hhrb98;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [3:0] divisor;
    logic       start;
    logic       sel;

    int tests;
    int fails;

    assign uio_in = {2'b00, sel, start, divisor};

    tt_um_seq_divider_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reads quotient (sel=0) and {dbz,000,rem} (sel=1); stays well inside one clock phase.
    task automatic read_res(output logic [7:0] qv, output logic [7:0] rv);
        sel = 1'b0; #1; qv = uo_out;
        sel = 1'b1; #1; rv = uo_out;
        sel = 1'b0;
    endtask

    // Single start pulse; lat = edges after the acceptance edge until done (capped at 20).
    task automatic run_div(input logic [7:0] dd, input logic [3:0] dv, output int lat);
        ui_in   = dd;
        divisor = dv;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 0;
        while (uio_out[7] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic div_case(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                            input logic [7:0] eq, input logic [7:0] er, input int elat);
        int lat;
        logic [7:0] qv, rv;
        run_div(dd, dv, lat);
        read_res(qv, rv);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_quot"}, qv, eq);
        chk({tag, "_rem"}, rv, er);
        $display("[TB] %0d / %0d -> quot=%0d sel1=0x%02h latency=%0d", dd, dv, qv, rv, lat);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        logic [7:0] qv, rv;
        logic [7:0] eq, er;
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        ui_in    = 8'h00;
        divisor  = 4'h0;
        start    = 1'b0;
        sel      = 1'b0;

        // Reset state
        #12;
        chk("rst_uo_q", uo_out, 8'h00);
        sel = 1'b1; #1;
        chk("rst_uo_r", uo_out, 8'h00);
        sel = 1'b0;
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'hC0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_uio_out", uio_out, 8'h00);

        // 200/7: busy for exactly 8 cycles, then 28 r4
        ui_in = 8'd200; divisor = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk("200_7_busy_after_accept", uio_out, 8'h40);
        busy_cnt = 0;
        while (uio_out[6] === 1'b1 && busy_cnt < 20) begin
            busy_cnt++;
            tick();
        end
        chk("200_7_busy_cycles", busy_cnt, 8);
        chk("200_7_done", uio_out, 8'h80);
        read_res(qv, rv);
        chk("200_7_quot", qv, 8'h1C);
        chk("200_7_sel1", rv, 8'h04);
        $display("[TB] 200 / 7 -> quot=%0d sel1=0x%02h busy_cycles=%0d", qv, rv, busy_cnt);

        div_case("255_1", 8'd255, 4'd1, 8'd255, 8'h00, 8);
        div_case("0_15", 8'd0, 4'd15, 8'd0, 8'h00, 8);
        div_case("9_13", 8'd9, 4'd13, 8'd0, 8'h09, 8);

        // Divide by zero: done on the acceptance edge, busy never rises
        div_case("15_0", 8'd15, 4'd0, 8'hFF, 8'h8F, 0);
        chk("15_0_busy_low", uio_out[6], 1'b0);

        // Abort mid-RUN with async reset, then a clean divide
        ui_in = 8'd100; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("abort_busy_before", uio_out, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("abort_uio_out", uio_out, 8'h00);
        sel = 1'b1; #1;
        chk("abort_uo_sel1", uo_out, 8'h00);
        sel = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("abort_stays_idle", uio_out, 8'h00);
        div_case("100_3_after_abort", 8'd100, 4'd3, 8'd33, 8'h01, 8);

        // Back-to-back with start held high; operand changes during RUN are ignored
        ui_in = 8'd100; divisor = 4'd3; start = 1'b1;
        tick();
        chk("b2b_accept1", uio_out, 8'h40);
        ui_in = 8'd77; divisor = 4'd5;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_still_busy", uio_out, 8'h40);
        tick();
        chk("b2b_done1", uio_out, 8'h80);
        read_res(qv, rv);
        chk("b2b_quot1", qv, 8'd33);
        chk("b2b_rem1", rv, 8'h01);
        $display("[TB] b2b 100 / 3 -> quot=%0d sel1=0x%02h", qv, rv);
        tick();
        chk("b2b_accept2", uio_out, 8'h40);
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_done2", uio_out, 8'h80);
        read_res(qv, rv);
        chk("b2b_quot2", qv, 8'd15);
        chk("b2b_rem2", rv, 8'h02);
        $display("[TB] b2b 77 / 5 -> quot=%0d sel1=0x%02h", qv, rv);

        // ena low for 3 cycles mid-RUN delays done by exactly 3
        ui_in = 8'd200; divisor = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        ena = 1'b0;
        tick(); tick(); tick();
        chk("ena_pause_busy", uio_out, 8'h40);
        ena = 1'b1;
        lat = 0;
        while (uio_out[7] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("ena_resume_lat", lat, 5);
        read_res(qv, rv);
        chk("ena_quot", qv, 8'h1C);
        chk("ena_rem", rv, 8'h04);
        $display("[TB] ena pause 200 / 7 -> quot=%0d sel1=0x%02h remaining=%0d", qv, rv, lat);

        // Full operand sweep against arithmetic reference
        for (int dd = 0; dd < 256; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                run_div(dd[7:0], dv[3:0], lat);
                read_res(qv, rv);
                if (dv == 0) begin
                    eq = 8'hFF;
                    er = 8'h8F;
                end else begin
                    eq = 8'(dd / dv);
                    er = 8'(dd % dv);
                end
                chk($sformatf("sweep_%0d_%0d", dd, dv), {8'h00, 8'(lat), rv, qv},
                    {8'h00, 8'((dv == 0) ? 0 : 8), er, eq});
            end
        end
        $display("[TB] sweep of 4096 operand pairs complete");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
